// File: rtl/iic_cfg_pkg.sv
// State encodings and the HMC588L register table for the IIC configuration sequencer.
// IIC_READBACK_EN adds the REQ_RD state used for write-then-read verification.
package iic_cfg_pkg;

`ifdef IIC_READBACK_EN
  typedef enum logic [2:0] {IDLE, REQ_WR, WAIT_GAP, DONE, ERROR, REQ_RD} state_t;
`else
  typedef enum logic [2:0] {IDLE, REQ_WR, WAIT_GAP, DONE, ERROR} state_t;
`endif

  localparam int TABLE_DEPTH = 16;

  localparam logic [7:0] CFG_ADDR [0:TABLE_DEPTH-1] = '{
    8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  localparam logic [7:0] CFG_DATA [0:TABLE_DEPTH-1] = '{
    8'h1F, 8'h00, 8'h0A, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

endpackage

// File: rtl/iic_cfg_rom.sv
// Combinational lookup of one {register address, data} table entry.
module iic_cfg_rom
  import iic_cfg_pkg::*;
(
  input  logic [3:0] idx,
  output logic [7:0] addr,
  output logic [7:0] data
);

  assign addr = CFG_ADDR[idx];
  assign data = CFG_DATA[idx];

endmodule

// File: rtl/iic_cfg_sequencer.sv
// Walks the constant register table, issuing one IIC write per entry with a bus-free gap between.
// Define IIC_READBACK_EN to read back each write and retry on mismatch.
module iic_cfg_sequencer
  import iic_cfg_pkg::*;
#(
  parameter int NUM_REGS       = 4,
  parameter int GAP_CYCLES     = 1024,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int RETRY_MAX      = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [3:0] err_idx,
  output logic       iicwr_req,
  output logic       iicrd_req,
  output logic [7:0] iic_addr,
  output logic [7:0] iic_wrdb,
  input  logic [7:0] iic_rddb,
  input  logic       iic_ack
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [16:0]   TMO_LAST = 17'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    IDX_LAST = 4'(NUM_REGS - 1);

  state_t        state, state_nxt;
  logic [3:0]    idx, idx_nxt;
  logic [GW-1:0] gap_cnt, gap_nxt;
  logic [16:0]   tmo_cnt, tmo_nxt;
  logic          busy_nxt, done_nxt, err_nxt, wr_nxt;
  logic [3:0]    err_idx_nxt;
  logic [7:0]    addr_nxt, wrdb_nxt;
  logic [3:0]    rom_idx;
  logic [7:0]    rom_addr, rom_data;

`ifdef IIC_READBACK_EN
  localparam int RW = $clog2(RETRY_MAX + 2);
  logic [RW-1:0] retry_cnt, retry_nxt;
  logic          redo, redo_nxt, rd_nxt;
`else
  logic unused_rb;
  assign unused_rb = (^iic_rddb) ^ (RETRY_MAX != 0);
  assign iicrd_req = 1'b0;
`endif

  function automatic logic [16:0] tmo_step(input logic [16:0] c);
    return (&c) ? c : c + 17'd1;
  endfunction

  // Entry 0 is loaded on start; every later load is the entry after the current one.
  assign rom_idx = (state == IDLE) ? 4'd0 : idx + 4'd1;

  iic_cfg_rom u_rom (
    .idx  (rom_idx),
    .addr (rom_addr),
    .data (rom_data)
  );

  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    gap_nxt     = gap_cnt;
    tmo_nxt     = '0;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    err_nxt     = err;
    err_idx_nxt = err_idx;
    wr_nxt      = iicwr_req;
    addr_nxt    = iic_addr;
    wrdb_nxt    = iic_wrdb;
`ifdef IIC_READBACK_EN
    rd_nxt      = iicrd_req;
    retry_nxt   = retry_cnt;
    redo_nxt    = redo;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = REQ_WR;
          busy_nxt  = 1'b1;
          err_nxt   = 1'b0;
          idx_nxt   = '0;
          wr_nxt    = 1'b1;
          addr_nxt  = rom_addr;
          wrdb_nxt  = rom_data;
`ifdef IIC_READBACK_EN
          retry_nxt = '0;
          redo_nxt  = 1'b0;
`endif
        end
      end
      REQ_WR: begin
        if (iic_ack) begin
          wr_nxt  = 1'b0;
          gap_nxt = '0;
`ifdef IIC_READBACK_EN
          state_nxt = REQ_RD;
          rd_nxt    = 1'b1;
`else
          state_nxt = WAIT_GAP;
`endif
        end else if (tmo_cnt == TMO_LAST) begin
          state_nxt = ERROR;
          wr_nxt    = 1'b0;
        end else begin
          tmo_nxt = tmo_step(tmo_cnt);
        end
      end
`ifdef IIC_READBACK_EN
      REQ_RD: begin
        if (iic_ack) begin
          rd_nxt  = 1'b0;
          gap_nxt = '0;
          if (iic_rddb == iic_wrdb) begin
            state_nxt = WAIT_GAP;
            retry_nxt = '0;
            redo_nxt  = 1'b0;
          end else if (retry_cnt == RW'(RETRY_MAX)) begin
            state_nxt = ERROR;
          end else begin
            state_nxt = WAIT_GAP;
            retry_nxt = retry_cnt + 1'b1;
            redo_nxt  = 1'b1;
          end
        end else if (tmo_cnt == TMO_LAST) begin
          state_nxt = ERROR;
          rd_nxt    = 1'b0;
        end else begin
          tmo_nxt = tmo_step(tmo_cnt);
        end
      end
`endif
      WAIT_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          gap_nxt = '0;
`ifdef IIC_READBACK_EN
          if (redo) begin
            redo_nxt  = 1'b0;
            state_nxt = REQ_WR;
            wr_nxt    = 1'b1;
          end else
`endif
          if (idx == IDX_LAST) begin
            state_nxt = DONE;
          end else begin
            idx_nxt   = idx + 4'd1;
            state_nxt = REQ_WR;
            wr_nxt    = 1'b1;
            addr_nxt  = rom_addr;
            wrdb_nxt  = rom_data;
          end
        end else begin
          gap_nxt = gap_cnt + 1'b1;
        end
      end
      DONE: begin
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      ERROR: begin
        err_nxt     = 1'b1;
        err_idx_nxt = idx;
        busy_nxt    = 1'b0;
        wr_nxt      = 1'b0;
`ifdef IIC_READBACK_EN
        rd_nxt      = 1'b0;
`endif
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      gap_cnt   <= '0;
      tmo_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_idx   <= '0;
      iicwr_req <= 1'b0;
      iic_addr  <= '0;
      iic_wrdb  <= '0;
`ifdef IIC_READBACK_EN
      iicrd_req <= 1'b0;
      retry_cnt <= '0;
      redo      <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      gap_cnt   <= gap_nxt;
      tmo_cnt   <= tmo_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
      err_idx   <= err_idx_nxt;
      iicwr_req <= wr_nxt;
      iic_addr  <= addr_nxt;
      iic_wrdb  <= wrdb_nxt;
`ifdef IIC_READBACK_EN
      iicrd_req <= rd_nxt;
      retry_cnt <= retry_nxt;
      redo      <= redo_nxt;
`endif
    end
  end

endmodule
